// File: rtl/hsv_core_ctrl_flow_if.sv
// Control-flow sequencer bus: commit ctrl_* inputs, flush handshake, CSR trap/mret
// updates and interrupt/WFI signalling. master = sequencer side.
interface hsv_core_ctrl_flow_if;
  logic        ctrl_flush_begin;
  logic        ctrl_trap;
  logic [4:0]  ctrl_trap_cause;
  logic [31:0] ctrl_trap_value;
  logic        ctrl_mode_return;
  logic        ctrl_wait_irq;
  logic [31:0] ctrl_next_pc;
  logic        ctrl_begin_irq;
  logic        flush_req;
  logic [31:0] flush_target;
  logic        flush_ack;
  logic        irq_pending;
  logic [4:0]  irq_cause;
  logic        csr_mstatus_mie;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        trap_we;
  logic [31:0] trap_mcause;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        mret_we;
  logic        wfi_active;

  modport master (
    input  ctrl_flush_begin, ctrl_trap, ctrl_trap_cause, ctrl_trap_value, ctrl_mode_return,
           ctrl_wait_irq, ctrl_next_pc, flush_ack, irq_pending, irq_cause, csr_mstatus_mie,
           csr_mtvec, csr_mepc,
    output ctrl_begin_irq, flush_req, flush_target, trap_we, trap_mcause, trap_epc, trap_tval,
           mret_we, wfi_active
  );

  modport slave (
    output ctrl_flush_begin, ctrl_trap, ctrl_trap_cause, ctrl_trap_value, ctrl_mode_return,
           ctrl_wait_irq, ctrl_next_pc, flush_ack, irq_pending, irq_cause, csr_mstatus_mie,
           csr_mtvec, csr_mepc,
    input  ctrl_begin_irq, flush_req, flush_target, trap_we, trap_mcause, trap_epc, trap_tval,
           mret_we, wfi_active
  );
endinterface

// File: rtl/hsv_core_ctrl_flow.sv
// Control-flow sequencer after commit: turns flush-class commits and interrupts into a
// pipeline flush handshake plus trap/mret CSR updates, and parks the core in WFI.
module hsv_core_ctrl_flow #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          VECTORED = 1'b1
) (
  input logic                  clk_core,
  input logic                  rst_core_n,
  hsv_core_ctrl_flow_if.master cf
);

  typedef enum logic [2:0] {RUN, DECIDE, IRQ, FLUSH_REQ, FLUSH_DROP, WFI} state_e;

  typedef struct packed {
    logic        trap_we;
    logic [31:0] mcause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic        mret_we;
    logic        flush_req;
    logic [31:0] target;
    logic        wfi_active;
    logic        wfi_flag;
  } regs_t;

  state_e      state_q, state_d;
  regs_t       r_q, r_d;
  logic        begin_irq;
  logic [31:0] base, irq_target;

  // Vectored mode only affects interrupts; exceptions always land on the base.
  assign base       = {cf.csr_mtvec[31:2], 2'b00};
  assign irq_target = (VECTORED && (cf.csr_mtvec[1:0] == 2'b01))
                      ? base + {25'b0, cf.irq_cause, 2'b00} : base;

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      state_q  <= RUN;
      r_q      <= '0;
      r_q.target <= RESET_PC;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    r_d.trap_we = 1'b0;
    r_d.mret_we = 1'b0;
    begin_irq  = 1'b0;
    case (state_q)
      RUN: begin
        if (cf.ctrl_flush_begin) begin
          state_d = DECIDE;
        end else if (cf.irq_pending && cf.csr_mstatus_mie) begin
          begin_irq = 1'b1;
          state_d   = IRQ;
        end
      end
      DECIDE: begin
        r_d.flush_req = 1'b1;
        state_d       = FLUSH_REQ;
        if (cf.ctrl_trap) begin
          r_d.trap_we = 1'b1;
          r_d.mcause  = {27'b0, cf.ctrl_trap_cause};
          r_d.epc     = cf.ctrl_next_pc;
          r_d.tval    = cf.ctrl_trap_value;
          r_d.target  = base;
        end else if (cf.ctrl_mode_return) begin
          r_d.mret_we = 1'b1;
          r_d.target  = cf.csr_mepc;
        end else if (cf.ctrl_wait_irq) begin
          r_d.target   = cf.ctrl_next_pc;
          r_d.wfi_flag = 1'b1;
        end else begin
          r_d.target = cf.ctrl_next_pc;
        end
      end
      IRQ: begin
        r_d.trap_we   = 1'b1;
        r_d.mcause    = {1'b1, 26'b0, cf.irq_cause};
        r_d.epc       = cf.ctrl_next_pc;
        r_d.tval      = '0;
        r_d.target    = irq_target;
        r_d.flush_req = 1'b1;
        state_d       = FLUSH_REQ;
      end
      FLUSH_REQ: begin
        if (cf.flush_ack) begin
          r_d.flush_req = 1'b0;
          state_d       = FLUSH_DROP;
        end
      end
      FLUSH_DROP: begin
        // Commit reloads its pc from flush_target during this cycle.
        if (r_q.wfi_flag) begin
          r_d.wfi_flag = 1'b0;
          state_d      = WFI;
        end else begin
          state_d = RUN;
        end
      end
      WFI: begin
        if (cf.irq_pending) begin
          if (cf.csr_mstatus_mie) begin
            begin_irq = 1'b1;
            state_d   = IRQ;
          end else begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
    r_d.wfi_active = (state_d == WFI);
  end

  assign cf.ctrl_begin_irq = begin_irq;
  assign cf.flush_req      = r_q.flush_req;
  assign cf.flush_target   = r_q.target;
  assign cf.trap_we        = r_q.trap_we;
  assign cf.trap_mcause    = r_q.mcause;
  assign cf.trap_epc       = r_q.epc;
  assign cf.trap_tval      = r_q.tval;
  assign cf.mret_we        = r_q.mret_we;
  assign cf.wfi_active     = r_q.wfi_active;

  a_flush_only_in_run: assert property (@(posedge clk_core) disable iff (!rst_core_n)
    cf.ctrl_flush_begin |-> (state_q == RUN))
    else $error("ctrl_flush_begin outside RUN");

endmodule

// File: tb/tb_hsv_core_ctrl_flow.sv
// Scoreboard bench for hsv_core_ctrl_flow: stimulus pushes cycle-stamped expected events,
// a negedge monitor pops and compares whenever the DUT shows a pulse or edge.
module tb_hsv_core_ctrl_flow;
  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam logic [6:0] F_IRQ = 7'b1000000, F_TRAP = 7'b0100000, F_MRET = 7'b0010000,
                         F_RISE = 7'b0001000, F_FALL = 7'b0000100, F_WR = 7'b0000010,
                         F_WF = 7'b0000001;

  typedef struct packed {
    logic [6:0]  f;
    logic [31:0] mcause, epc, tval, target;
    int          c;
  } ev_t;

  logic clk_core = 1'b0;
  logic rst_core_n = 1'b0;
  always #5 clk_core = ~clk_core;

  int cyc = 0;
  always @(posedge clk_core) cyc <= cyc + 1;

  hsv_core_ctrl_flow_if if0();
  hsv_core_ctrl_flow_if if1();

  hsv_core_ctrl_flow #(.RESET_PC(RPC), .VECTORED(1'b1)) dut (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .cf(if0.master));
  hsv_core_ctrl_flow #(.RESET_PC(32'h0), .VECTORED(1'b0)) dut_nv (
    .clk_core(clk_core), .rst_core_n(rst_core_n), .cf(if1.master));

  // Each stage ack is a registered copy of flush_req; force/block override it.
  logic ack_q0 = 1'b0, ack_q1 = 1'b0, ack_force, ack_block;
  always @(posedge clk_core) begin
    ack_q0 <= if0.flush_req;
    ack_q1 <= if1.flush_req;
  end
  assign if0.flush_ack = (ack_q0 | ack_force) & ~ack_block;
  assign if1.flush_ack = (ack_q1 | ack_force) & ~ack_block;

  assign if1.ctrl_flush_begin = if0.ctrl_flush_begin;
  assign if1.ctrl_trap        = if0.ctrl_trap;
  assign if1.ctrl_trap_cause  = if0.ctrl_trap_cause;
  assign if1.ctrl_trap_value  = if0.ctrl_trap_value;
  assign if1.ctrl_mode_return = if0.ctrl_mode_return;
  assign if1.ctrl_wait_irq    = if0.ctrl_wait_irq;
  assign if1.ctrl_next_pc     = if0.ctrl_next_pc;
  assign if1.irq_pending      = if0.irq_pending;
  assign if1.irq_cause        = if0.irq_cause;
  assign if1.csr_mstatus_mie  = if0.csr_mstatus_mie;
  assign if1.csr_mtvec        = if0.csr_mtvec;
  assign if1.csr_mepc         = if0.csr_mepc;

  ev_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  function automatic ev_t mk(int c, logic [6:0] f, logic [31:0] mc, logic [31:0] ep,
                             logic [31:0] tv, logic [31:0] tg);
    ev_t e;
    e.f = f; e.mcause = mc; e.epc = ep; e.tval = tv; e.target = tg; e.c = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, req);
  endtask

  task automatic monitor();
    logic pr, pw;
    ev_t  a, e;
    pr = 1'b0; pw = 1'b0;
    forever begin
      @(negedge clk_core);
      if (!rst_core_n) begin
        pr = 1'b0; pw = 1'b0;
      end else begin
        a   = '0;
        a.f = {if0.ctrl_begin_irq, if0.trap_we, if0.mret_we, if0.flush_req & ~pr,
               ~if0.flush_req & pr, if0.wfi_active & ~pw, ~if0.wfi_active & pw};
        if (if0.trap_we) begin
          a.mcause = if0.trap_mcause; a.epc = if0.trap_epc; a.tval = if0.trap_tval;
        end
        if (a.f[3]) a.target = if0.flush_target;
        a.c = cyc;
        pr = if0.flush_req; pw = if0.wfi_active;
        if (a.f != 7'b0) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_event: got flags=%b at cycle %0d, required no event", a.f, a.c);
          end else begin
            e = exp_q.pop_front();
            if (a == e) n_pass++;
            else $display("FAIL event: got f=%b mc=%h epc=%h tv=%h tgt=%h cyc=%0d required f=%b mc=%h epc=%h tv=%h tgt=%h cyc=%0d",
                          a.f, a.mcause, a.epc, a.tval, a.target, a.c,
                          e.f, e.mcause, e.epc, e.tval, e.target, e.c);
          end
        end
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_core);
    #1;
  endtask

  // kind: 0 plain, 1 trap, 2 mret, 3 wfi. Returns two cycles after flush_begin.
  task automatic flush(input int kind, input logic [31:0] npc, input logic [4:0] cause,
                       input logic [31:0] tval, input logic [31:0] tgt, input logic [31:0] mc,
                       input logic [31:0] ep, input logic [31:0] tv, input bit tail);
    int n;
    logic [6:0] f;
    n = cyc;
    f = F_RISE | ((kind == 1) ? F_TRAP : 7'b0) | ((kind == 2) ? F_MRET : 7'b0);
    exp_q.push_back(mk(n + 2, f, mc, ep, tv, tgt));
    if (tail) begin
      exp_q.push_back(mk(n + 4, F_FALL, 0, 0, 0, 0));
      if (kind == 3) exp_q.push_back(mk(n + 5, F_WR, 0, 0, 0, 0));
    end
    if0.ctrl_flush_begin = 1'b1;
    tick(1);
    if0.ctrl_flush_begin = 1'b0;
    if0.ctrl_next_pc     = npc;
    if0.ctrl_trap        = (kind == 1);
    if0.ctrl_trap_cause  = cause;
    if0.ctrl_trap_value  = tval;
    if0.ctrl_mode_return = (kind == 2);
    if0.ctrl_wait_irq    = (kind == 3);
    tick(1);
    if0.ctrl_trap = 1'b0; if0.ctrl_mode_return = 1'b0; if0.ctrl_wait_irq = 1'b0;
  endtask

  initial begin
    int m;
    fork monitor(); join_none
    if0.ctrl_flush_begin = 1'b0; if0.ctrl_trap = 1'b0; if0.ctrl_trap_cause = '0;
    if0.ctrl_trap_value = '0; if0.ctrl_mode_return = 1'b0; if0.ctrl_wait_irq = 1'b0;
    if0.ctrl_next_pc = '0; if0.irq_pending = 1'b0; if0.irq_cause = '0;
    if0.csr_mstatus_mie = 1'b0; if0.csr_mtvec = '0; if0.csr_mepc = '0;
    ack_force = 1'b1; ack_block = 1'b0;

    // Reset values and a quiet idle window with flush_ack held high
    tick(3);
    chk("rst_flush_req", {31'b0, if0.flush_req}, 0);
    chk("rst_target", if0.flush_target, RPC);
    chk("rst_nv_target", if1.flush_target, 32'h0);
    chk("rst_trap_we", {31'b0, if0.trap_we}, 0);
    chk("rst_mret_we", {31'b0, if0.mret_we}, 0);
    chk("rst_wfi_active", {31'b0, if0.wfi_active}, 0);
    chk("rst_mcause", if0.trap_mcause, 0);
    rst_core_n = 1'b1;
    tick(10);
    chk("idle_target", if0.flush_target, RPC);
    chk("idle_flush_req", {31'b0, if0.flush_req}, 0);
    ack_force = 1'b0;
    tick(2);

    // Exception
    if0.csr_mtvec = 32'h8000_0001;
    flush(1, 32'h100, 5'd2, 32'hDEAD, 32'h8000_0000, 32'h2, 32'h100, 32'hDEAD, 1'b1);
    tick(4);

    // mret
    if0.csr_mepc = 32'h200;
    flush(2, 32'h1234, 5'd0, 32'h0, 32'h200, 0, 0, 0, 1'b1);
    tick(4);

    // Interrupt from RUN, vectored vs direct instance
    if0.ctrl_next_pc = 32'h40; if0.irq_cause = 5'd7; if0.csr_mstatus_mie = 1'b1;
    if0.irq_pending = 1'b1;
    m = cyc;
    exp_q.push_back(mk(m, F_IRQ, 0, 0, 0, 0));
    exp_q.push_back(mk(m + 2, F_TRAP | F_RISE, 32'h8000_0007, 32'h40, 32'h0, 32'h8000_001C));
    exp_q.push_back(mk(m + 4, F_FALL, 0, 0, 0, 0));
    tick(1);
    if0.irq_pending = 1'b0;
    tick(1);
    chk("nv_irq_target", if1.flush_target, 32'h8000_0000);
    chk("nv_irq_flush_req", {31'b0, if1.flush_req}, 1);
    chk("nv_irq_mcause", if1.trap_mcause, 32'h8000_0007);
    tick(4);

    // WFI woken by irq with MIE clear: back to RUN, no trap
    if0.csr_mstatus_mie = 1'b0;
    flush(3, 32'h44, 5'd0, 32'h0, 32'h44, 0, 0, 0, 1'b1);
    tick(5);
    m = cyc;
    if0.irq_pending = 1'b1;
    exp_q.push_back(mk(m + 1, F_WF, 0, 0, 0, 0));
    tick(1);
    if0.irq_pending = 1'b0; if0.csr_mstatus_mie = 1'b1;
    tick(3);

    // WFI woken by irq with MIE set: interrupt entry, epc is the insn after wfi
    flush(3, 32'h44, 5'd0, 32'h0, 32'h44, 0, 0, 0, 1'b1);
    tick(5);
    m = cyc;
    if0.irq_pending = 1'b1;
    exp_q.push_back(mk(m, F_IRQ, 0, 0, 0, 0));
    exp_q.push_back(mk(m + 1, F_WF, 0, 0, 0, 0));
    exp_q.push_back(mk(m + 2, F_TRAP | F_RISE, 32'h8000_0007, 32'h44, 32'h0, 32'h8000_001C));
    exp_q.push_back(mk(m + 4, F_FALL, 0, 0, 0, 0));
    tick(1);
    if0.irq_pending = 1'b0;
    tick(5);

    // irq and flush_begin together: flush first, irq on return to RUN
    m = cyc;
    if0.irq_pending = 1'b1;
    flush(0, 32'h300, 5'd0, 32'h0, 32'h300, 0, 0, 0, 1'b1);
    exp_q.push_back(mk(m + 5, F_IRQ, 0, 0, 0, 0));
    exp_q.push_back(mk(m + 7, F_TRAP | F_RISE, 32'h8000_0007, 32'h300, 32'h0, 32'h8000_001C));
    exp_q.push_back(mk(m + 9, F_FALL, 0, 0, 0, 0));
    tick(4);
    if0.irq_pending = 1'b0;
    tick(5);

    // Reset asserted while waiting for flush_ack
    ack_block = 1'b1;
    flush(0, 32'h500, 5'd0, 32'h0, 32'h500, 0, 0, 0, 1'b0);
    tick(1);
    chk("pre_rst_flush_req", {31'b0, if0.flush_req}, 1);
    rst_core_n = 1'b0;
    #1;
    chk("midrst_flush_req", {31'b0, if0.flush_req}, 0);
    chk("midrst_nv_flush_req", {31'b0, if1.flush_req}, 0);
    chk("midrst_target", if0.flush_target, RPC);
    chk("midrst_mcause", if0.trap_mcause, 0);
    tick(1);
    rst_core_n = 1'b1; ack_block = 1'b0;
    tick(2);
    flush(0, 32'h600, 5'd0, 32'h0, 32'h600, 0, 0, 0, 1'b1);
    tick(5);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
